// File: rtl/mux_arb_pkg.sv
// Shared definitions for the two-requester mux arbiter: state encoding and
// parameter defaults.
package mux_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  localparam int W_DEF        = 1;
  localparam int MAX_HOLD_DEF = 8;
endpackage

// File: rtl/mux2_w.sv
// W-bit 2:1 datapath mux; sel = 1 picks b.
module mux2_w #(
  parameter int W = 1
) (
  input  logic         sel,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/mux_arbiter.sv
// Two-requester arbiter owning a shared W-bit path: alternating priority,
// bounded tenure under contention, one dead cycle between owners.
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req_a,
  input  logic         req_b,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         sel,
  output logic [W-1:0] out,
  output logic         out_valid
);
  localparam logic [7:0] HMAX = 8'(MAX_HOLD);

  arb_state_t state, state_n;
  logic [7:0] hcnt;
  logic       last_b;

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE, GAP: begin
        // last_b = 1 means B was served last, so A wins a tie
        if (req_a && (!req_b || last_b)) state_n = OWN_A;
        else if (req_b)                  state_n = OWN_B;
        else                             state_n = IDLE;
      end
      OWN_A: if (!req_a || (hcnt == HMAX && req_b)) state_n = GAP;
      OWN_B: if (!req_b || (hcnt == HMAX && req_a)) state_n = GAP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      sel    <= 1'b0;
      hcnt   <= 8'd0;
      last_b <= 1'b1;
    end else begin
      state <= state_n;
      gnt_a <= (state_n == OWN_A);
      gnt_b <= (state_n == OWN_B);
      if (state_n == OWN_A && state != OWN_A) begin
        sel  <= 1'b0;
        hcnt <= 8'd1;
      end else if (state_n == OWN_B && state != OWN_B) begin
        sel  <= 1'b1;
        hcnt <= 8'd1;
      end else if ((state == OWN_A || state == OWN_B) && hcnt != HMAX) begin
        hcnt <= hcnt + 8'd1;
      end
      if (state == OWN_A && state_n != OWN_A) last_b <= 1'b0;
      if (state == OWN_B && state_n != OWN_B) last_b <= 1'b1;
    end
  end

  mux2_w #(.W(W)) u_mux (
    .sel (sel),
    .a   (a),
    .b   (b),
    .y   (out)
  );

  assign out_valid = gnt_a | gnt_b;
endmodule

// File: tb/tb_mux_arbiter.sv
// Scoreboard bench for mux_arbiter (W = 4, MAX_HOLD = 4): directed scenarios
// followed by random request traffic with occasional resets.
module tb_mux_arbiter;
  localparam int W        = 4;
  localparam int MAX_HOLD = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_a = 1'b0;
  logic         req_b = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         gnt_a, gnt_b, sel, out_valid;
  logic [W-1:0] out;

  mux_arbiter #(.W(W), .MAX_HOLD(MAX_HOLD)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_a     (req_a),
    .req_b     (req_b),
    .a         (a),
    .b         (b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .sel       (sel),
    .out       (out),
    .out_valid (out_valid)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic ga;
    logic gb;
    logic s;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference: who owns the path (0 none, 1 A, 2 B), how long it has held
  // it, and whose turn a tie goes to.
  int   owner    = 0;
  int   held     = 0;
  bit   prefer_a = 1'b1;
  bit   sel_m    = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advances the reference by one clock using the inputs the DUT just sampled.
  task automatic model_step();
    bit mine, other;
    if (reset) begin
      owner = 0; held = 0; prefer_a = 1'b1; sel_m = 1'b0;
    end else if (owner != 0) begin
      mine  = (owner == 1) ? req_a : req_b;
      other = (owner == 1) ? req_b : req_a;
      if (!mine || (held >= MAX_HOLD && other)) begin
        prefer_a = (owner == 2);
        owner    = 0;
      end else begin
        held++;
      end
    end else begin
      if (req_a && (!req_b || prefer_a)) begin
        owner = 1; held = 1; sel_m = 1'b0;
      end else if (req_b) begin
        owner = 2; held = 1; sel_m = 1'b1;
      end
    end
  endtask

  task automatic cycle(input logic ra, input logic rb, input logic rst,
                       input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    @(posedge clock);
    #1;
    model_step();
    e.ga = (owner == 1);
    e.gb = (owner == 2);
    e.s  = sel_m;
    q.push_back(e);
    req_a = ra; req_b = rb; reset = rst; a = av; b = bv;
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [W-1:0] out_exp;
      e = q.pop_front();
      out_exp = e.s ? b : a;
      chk("gnt_a",     8'(gnt_a),         8'(e.ga));
      chk("gnt_b",     8'(gnt_b),         8'(e.gb));
      chk("sel",       8'(sel),           8'(e.s));
      chk("out",       8'(out),           8'(out_exp));
      chk("out_valid", 8'(out_valid),     8'(e.ga | e.gb));
      chk("mutex",     8'(gnt_a & gnt_b), 8'd0);
    end
  end

  initial begin
    logic ra, rb;
    int   guard;
    ra = 1'b0; rb = 1'b0;

    // reset, then A alone for 5 cycles and release
    repeat (2) cycle(0, 0, 1, 4'h0, 4'h0);
    repeat (5) cycle(1, 0, 0, 4'h3, 4'h5);
    repeat (3) cycle(0, 0, 0, 4'h3, 4'h5);

    // simultaneous requests right after reset: A first, then B after a gap
    repeat (2) cycle(0, 0, 1, 4'h0, 4'h0);
    repeat (3) cycle(1, 1, 0, 4'h1, 4'h2);
    repeat (6) cycle(0, 1, 0, 4'h1, 4'h2);
    repeat (2) cycle(0, 0, 0, 4'h1, 4'h2);

    // A held, B joins from cycle 2: forced release after MAX_HOLD
    repeat (2)  cycle(1, 0, 0, 4'h7, 4'hA);
    repeat (12) cycle(1, 1, 0, 4'h7, 4'hA);
    repeat (2)  cycle(0, 0, 0, 4'h7, 4'hA);

    // A alone for 20 cycles: never forced off
    repeat (20) cycle(1, 0, 0, 4'hC, 4'hD);
    repeat (2)  cycle(0, 0, 0, 4'hC, 4'hD);

    // reset in the middle of a B tenure, then a tie goes to A
    repeat (4) cycle(0, 1, 0, 4'h9, 4'h6);
    cycle(1, 1, 1, 4'h9, 4'h6);
    repeat (4) cycle(1, 1, 0, 4'h9, 4'h6);
    repeat (2) cycle(0, 0, 0, 4'h9, 4'h6);

    // random traffic: sticky requests, random data, rare resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) ra = ~ra;
      if ($urandom_range(7) == 0) rb = ~rb;
      cycle(ra, rb, ($urandom_range(99) == 0), 4'($urandom), 4'($urandom));
    end
    cycle(0, 0, 0, 4'h0, 4'h0);

    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clock);
      guard++;
    end
    chk("drain", 8'(q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 Parameter W, default 1, data width of each input and of the output.
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles while the other side requests; legal range 2..255.
REQ-003 clock  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-005 req_a  input  1  requester A wants the shared path; held high for the whole use.
REQ-006 req_b  input  1  requester B wants the shared path; held high for the whole use.
REQ-007 a  input  W  data from requester A.
REQ-008 b  input  W  data from requester B.
REQ-009 gnt_a  output  1  registered; A owns the path.
REQ-010 gnt_b  output  1  registered; B owns the path.
REQ-011 sel  output  1  registered mux select: 0 = A, 1 = B.
REQ-012 out  output  W  combinational: b when sel is 1, else a.
REQ-013 out_valid  output  1  equals gnt_a OR gnt_b.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, OWN_A, OWN_B, GAP.
REQ-015 gnt_a SHALL be high only in OWN_A, gnt_b only in OWN_B; both SHALL never be high together.
REQ-016 IDLE: if only one req is high, move to that requester's OWN state on the next posedge.
REQ-017 IDLE: if both reqs are high, the requester not served last SHALL win; the priority flag is last_b (0 = A served last).
REQ-018 Grant latency SHALL be exactly 1 cycle: req sampled high in IDLE, grant high from the next posedge.
REQ-019 sel SHALL update on the same edge as entry into OWN_A (to 0) or OWN_B (to 1), and hold its value in IDLE and GAP.
REQ-020 On entry to an OWN state, hold counter hcnt (8 bits) SHALL load 1; it increments each cycle in OWN and saturates at MAX_HOLD.
REQ-021 OWN_x: if req_x falls, go to GAP on the next posedge.
REQ-022 OWN_x: if hcnt equals MAX_HOLD and the other req is high, go to GAP even though req_x is still high (forced release).
REQ-023 OWN_x: if hcnt equals MAX_HOLD and the other req is low, remain in OWN_x with no limit.
REQ-024 On leaving OWN_x, last_b SHALL be set to x == B.
REQ-025 GAP SHALL last exactly one cycle with no grant; the next state is chosen by the IDLE rules (REQ-016/017) from the reqs sampled in GAP, else IDLE.
REQ-026 A forced-off requester that still holds req SHALL be granted again only after the other side's tenure plus one GAP cycle.
REQ-027 If req_a and req_b both change on the same edge as a forced release, the release SHALL take precedence.

Reset
REQ-028 While reset is high at a posedge: state = IDLE, gnt_a = 0, gnt_b = 0, sel = 0, hcnt = 0, last_b = 1 (A has first priority).
REQ-029 Reset asserted mid-tenure SHALL drop the grant on that same edge, with no GAP cycle.
REQ-030 The first arbitration after reset deassertion SHALL follow REQ-016/017.

Structure
REQ-031 The state encodings (IDLE = 0, OWN_A = 1, OWN_B = 2, GAP = 3) and the defaults for W and MAX_HOLD SHALL live in a shared package, mux_arb_pkg.
REQ-032 The datapath SHALL be a separate sub-module, mux2_w (W-bit 2:1 mux), instantiated once; the FSM, counter and priority flag stay in mux_arbiter.

Verification (MAX_HOLD = 4, W = 4)
REQ-033 Reset, then req_a = 1 at cycle 0 -> gnt_a = 1 and sel = 0 at cycle 1; out = a; req_a = 0 at cycle 5 -> GAP at cycle 6, IDLE at cycle 7.
REQ-034 req_a and req_b both rise in IDLE right after reset -> gnt_a first; after A releases and one GAP cycle, gnt_b = 1 and sel = 1.
REQ-035 A holds req while B requests from cycle 2 -> gnt_a high for exactly 4 cycles, 1 GAP cycle, then gnt_b = 1; out follows b (b = 4'hA -> out = 4'hA).
REQ-036 A alone holds req for 20 cycles -> gnt_a stays high throughout, with no forced release.
REQ-037 Reset pulsed during OWN_B -> gnt_b = 0 on that edge, sel = 0, state IDLE; the next simultaneous request is granted to A.
REQ-038 Every cycle of all tests: gnt_a AND gnt_b is never 1, and out_valid equals gnt_a OR gnt_b.
